kogge_stone_addsub_pipe: RTL and testbench

KOGGE_STONE_ADDSUB_PIPE -- requirements
Module: kogge_stone_addsub_pipe

---
 rtl/kogge_stone_addsub_pipe.sv | 201 ++++++++++++++++++++
 tb/tb_kogge_stone_addsub_pipe.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/kogge_stone_addsub_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with a global-stall valid/ready pipeline.
// Optional signed saturation is built only when KSA_SAT_EN is defined.
module kogge_stone_addsub_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic [3:0]       flags
);

    localparam int LEVELS = $clog2(WIDTH);
    localparam int MID    = LEVELS / 2;

    // Handshake: a beat moves on a rising edge with in_valid && in_ready, a result leaves
    // with out_valid && out_ready; when in_ready is low every stage holds its contents.
    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    logic [WIDTH-1:0] a_s, b_s;
    logic             sub_s, v_s;
`ifdef KSA_SAT_EN
    logic             sat_s, sat_m;
`else
    logic             unused_sat;
    assign unused_sat = sat;
`endif

    generate
        if (STAGES == 3) begin : g_in
            logic [WIDTH-1:0] a_q, b_q;
            logic             sub_q, v_q;
`ifdef KSA_SAT_EN
            logic             sat_q;
`endif
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q   <= 1'b0;
                    a_q   <= '0;
                    b_q   <= '0;
                    sub_q <= 1'b0;
`ifdef KSA_SAT_EN
                    sat_q <= 1'b0;
`endif
                end else if (adv) begin
                    v_q   <= in_valid;
                    a_q   <= a;
                    b_q   <= b;
                    sub_q <= sub;
`ifdef KSA_SAT_EN
                    sat_q <= sat;
`endif
                end
            end
            assign a_s   = a_q;
            assign b_s   = b_q;
            assign sub_s = sub_q;
            assign v_s   = v_q;
`ifdef KSA_SAT_EN
            assign sat_s = sat_q;
`endif
        end else begin : g_in_bypass
            assign a_s   = a;
            assign b_s   = b;
            assign sub_s = sub;
            assign v_s   = in_valid;
`ifdef KSA_SAT_EN
            assign sat_s = sat;
`endif
        end
    endgenerate

    // Carry-in is folded into bit 0's generate, so prefix G[i] is the carry into bit i+1.
    logic [WIDTH-1:0] bx, p0, g0;
    assign bx = b_s ^ {WIDTH{sub_s}};
    assign p0 = a_s ^ bx;
    assign g0 = (a_s & bx) | {{(WIDTH-1){1'b0}}, p0[0] & sub_s};

    logic [WIDTH-1:0] g_lo [0:MID];
    logic [WIDTH-1:0] p_lo [0:MID];
    assign g_lo[0] = g0;
    assign p_lo[0] = p0;

    generate
        for (genvar k = 1; k <= MID; k++) begin : g_lvl_lo
            localparam int D = 1 << (k - 1);
            localparam logic [WIDTH-1:0] LOW = {WIDTH{1'b1}} >> (WIDTH - D);
            assign g_lo[k] = g_lo[k-1] | (p_lo[k-1] & (g_lo[k-1] << D));
            assign p_lo[k] = p_lo[k-1] & ((p_lo[k-1] << D) | LOW);
        end
    endgenerate

    logic [WIDTH-1:0] g_src, p_src, p0_src;
    logic             cin_src, v_src;

    generate
        if (STAGES >= 2) begin : g_mid
            logic [WIDTH-1:0] g_q, p_q, p0_q;
            logic             cin_q, v_q;
`ifdef KSA_SAT_EN
            logic             sat_q;
`endif
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q   <= 1'b0;
                    g_q   <= '0;
                    p_q   <= '0;
                    p0_q  <= '0;
                    cin_q <= 1'b0;
`ifdef KSA_SAT_EN
                    sat_q <= 1'b0;
`endif
                end else if (adv) begin
                    v_q   <= v_s;
                    g_q   <= g_lo[MID];
                    p_q   <= p_lo[MID];
                    p0_q  <= p0;
                    cin_q <= sub_s;
`ifdef KSA_SAT_EN
                    sat_q <= sat_s;
`endif
                end
            end
            assign g_src   = g_q;
            assign p_src   = p_q;
            assign p0_src  = p0_q;
            assign cin_src = cin_q;
            assign v_src   = v_q;
`ifdef KSA_SAT_EN
            assign sat_m   = sat_q;
`endif
        end else begin : g_mid_bypass
            assign g_src   = g_lo[MID];
            assign p_src   = p_lo[MID];
            assign p0_src  = p0;
            assign cin_src = sub_s;
            assign v_src   = v_s;
`ifdef KSA_SAT_EN
            assign sat_m   = sat_s;
`endif
        end
    endgenerate

    logic [WIDTH-1:0] g_hi [MID:LEVELS];
    logic [WIDTH-1:0] p_hi [MID:LEVELS-1];
    assign g_hi[MID] = g_src;
    assign p_hi[MID] = p_src;

    generate
        for (genvar k = MID + 1; k <= LEVELS; k++) begin : g_lvl_hi
            localparam int D = 1 << (k - 1);
            localparam logic [WIDTH-1:0] LOW = {WIDTH{1'b1}} >> (WIDTH - D);
            assign g_hi[k] = g_hi[k-1] | (p_hi[k-1] & (g_hi[k-1] << D));
            if (k < LEVELS) begin : g_p
                assign p_hi[k] = p_hi[k-1] & ((p_hi[k-1] << D) | LOW);
            end
        end
    endgenerate

    logic [WIDTH-1:0] gf, wrap, res;
    logic             cout, ovf;
    assign gf   = g_hi[LEVELS];
    assign cout = gf[WIDTH-1];
    assign ovf  = gf[WIDTH-1] ^ gf[WIDTH-2];

    always_comb begin
        wrap = p0_src ^ {gf[WIDTH-2:0], cin_src};
        res  = wrap;
`ifdef KSA_SAT_EN
        // On overflow the carry out tells the direction: set means both operands were negative.
        if (sat_m && ovf) begin
            res = cout ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            flags     <= 4'b0000;
        end else if (adv) begin
            out_valid <= v_src;
            if (v_src) begin
                sum   <= res;
                flags <= {cout, ovf, res[WIDTH-1], (res == '0)};
            end
        end
    end

endmodule

// File: tb/tb_kogge_stone_addsub_pipe.sv
// Bench for kogge_stone_addsub_pipe: drives STAGES=1,2,3 instances in lockstep and
// checks each against its own expected queue; follows KSA_SAT_EN like the design.
module tb_kogge_stone_addsub_pipe;

`ifdef KSA_SAT_EN
    localparam bit SAT_BUILD = 1'b1;
`else
    localparam bit SAT_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, sub, sat, out_ready;
    logic [31:0] a, b;
    logic        in_ready_s  [3];
    logic        out_valid_s [3];
    logic [31:0] sum_s       [3];
    logic [3:0]  flags_s     [3];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        kogge_stone_addsub_pipe #(.WIDTH(32), .STAGES(gi + 1)) u_dut (
            .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s[gi]),
            .a(a), .b(b), .sub(sub), .sat(sat), .out_valid(out_valid_s[gi]),
            .out_ready(out_ready), .sum(sum_s[gi]), .flags(flags_s[gi])
        );
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int stall_waits = 0;
    logic lat_en = 1'b0;
    logic        have_hold [3];
    logic [35:0] hold_val  [3];
    int          cons_cnt  [3];
    logic [35:0] exp_q0[$], exp_q1[$], exp_q2[$];
    int          cyc_q0[$], cyc_q1[$], cyc_q2[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    function automatic logic [35:0] model(input logic [31:0] av, input logic [31:0] bv,
                                          input logic sv, input logic tv);
        logic [31:0] bi, s;
        logic [32:0] r;
        logic        o;
        bi = bv ^ {32{sv}};
        r  = {1'b0, av} + {1'b0, bi} + {32'd0, sv};
        o  = (av[31] == bi[31]) && (r[31] != av[31]);
        s  = r[31:0];
        if (SAT_BUILD && tv && o) s = av[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        return {r[32], o, s[31], (s == 32'd0), s};
    endfunction

    task automatic push_exp(input logic [35:0] e);
        exp_q0.push_back(e); exp_q1.push_back(e); exp_q2.push_back(e);
        cyc_q0.push_back(cyc); cyc_q1.push_back(cyc); cyc_q2.push_back(cyc);
    endtask

    task automatic flush_exp();
        exp_q0.delete(); exp_q1.delete(); exp_q2.delete();
        cyc_q0.delete(); cyc_q1.delete(); cyc_q2.delete();
    endtask

    function automatic int q_size(input int k);
        case (k)
            0: return exp_q0.size();
            1: return exp_q1.size();
            default: return exp_q2.size();
        endcase
    endfunction

    task automatic pop_exp(input int k, output logic [35:0] e, output int c);
        case (k)
            0: begin e = exp_q0.pop_front(); c = cyc_q0.pop_front(); end
            1: begin e = exp_q1.pop_front(); c = cyc_q1.pop_front(); end
            default: begin e = exp_q2.pop_front(); c = cyc_q2.pop_front(); end
        endcase
    endtask

    // Called at negedge+1; offers one beat once all three instances are ready.
    task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic sv,
                        input logic tv, input logic [35:0] e);
        int w = 0;
        while (!(in_ready_s[0] && in_ready_s[1] && in_ready_s[2]) && w < 50) begin
            @(negedge clk); #1;
            w++;
        end
        if (w >= 50) begin
            checks++; errors++;
            $display("FAIL send_timeout: got no in_ready in %0d cycles, required in_ready=1", w);
            return;
        end
        stall_waits += w;
        a = av; b = bv; sub = sv; sat = tv; in_valid = 1'b1;
        push_exp(e);
        @(negedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic mon_one(input int k);
        logic [35:0] got, e;
        int c;
        got = {flags_s[k], sum_s[k]};
        if (have_hold[k])
            chk($sformatf("hold_s%0d", k + 1), {27'd0, out_valid_s[k], got}, {27'd0, 1'b1, hold_val[k]});
        have_hold[k] = out_valid_s[k] && !out_ready;
        hold_val[k]  = got;
        if (out_valid_s[k] && out_ready) begin
            cons_cnt[k]++;
            if (q_size(k) == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_s%0d: got result %h, required no result", k + 1, got);
            end else begin
                pop_exp(k, e, c);
                chk($sformatf("result_s%0d", k + 1), {28'd0, got}, {28'd0, e});
                if (lat_en) chk($sformatf("latency_s%0d", k + 1), 64'(cyc - c), 64'(k + 1));
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            have_hold[k] = 1'b0; hold_val[k] = '0; cons_cnt[k] = 0;
        end
        forever begin
            @(negedge clk); #2;
            if (!rst_n) begin
                for (int k = 0; k < 3; k++) have_hold[k] = 1'b0;
            end else begin
                for (int k = 0; k < 3; k++) mon_one(k);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base [3];
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; sat = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_out_valid_s%0d", k + 1), 64'(out_valid_s[k]), 64'd0);
            chk($sformatf("rst_sum_s%0d", k + 1), 64'(sum_s[k]), 64'd0);
            chk($sformatf("rst_flags_s%0d", k + 1), 64'(flags_s[k]), 64'd0);
            chk($sformatf("rst_in_ready_s%0d", k + 1), 64'(in_ready_s[k]), 64'd1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        for (int k = 0; k < 3; k++)
            chk($sformatf("post_rst_in_ready_s%0d", k + 1), 64'(in_ready_s[k]), 64'd1);

        // Directed vectors, expected {cout, ovf, neg, zero, sum} worked out by hand.
        lat_en = 1'b1;
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {4'b1001, 32'h0000_0000});
        send(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, {4'b0010, 32'hFFFF_FFFE});
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1,
             SAT_BUILD ? {4'b0100, 32'h7FFF_FFFF} : {4'b0110, 32'h8000_0000});
        send(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1,
             SAT_BUILD ? {4'b1110, 32'h8000_0000} : {4'b1100, 32'h7FFF_FFFF});
        send(32'h0000_000A, 32'h0000_000A, 1'b1, 1'b0, {4'b1001, 32'h0000_0000});
        send(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, {4'b0001, 32'h0000_0000});
        send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, {4'b0000, 32'h2345_6789});
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {4'b0110, 32'h8000_0000});
        send(32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0, {4'b0010, 32'hFFFF_FFFF});
        send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, {4'b1101, 32'h0000_0000});
        send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1,
             SAT_BUILD ? {4'b1110, 32'h8000_0000} : {4'b1101, 32'h0000_0000});
        idle(8);

        // Full-rate stream: 100 random beats, consumer always ready.
        for (int k = 0; k < 3; k++) base[k] = cons_cnt[k];
        stall_waits = 0;
        for (int i = 0; i < 100; i++) begin
            logic [31:0] ra, rb;
            logic        rs, rt;
            ra = $urandom(); rb = $urandom();
            rs = 1'($urandom_range(0, 1)); rt = 1'($urandom_range(0, 1));
            if (i % 10 == 0) rb = ra;
            send(ra, rb, rs, rt, model(ra, rb, rs, rt));
        end
        chk("stream_input_stalls", 64'(stall_waits), 64'd0);
        idle(6);
        for (int k = 0; k < 3; k++)
            chk($sformatf("stream_count_s%0d", k + 1), 64'(cons_cnt[k] - base[k]), 64'd100);

        // Consumer stalls for 4 cycles while 3 beats are offered back to back.
        lat_en = 1'b0;
        out_ready = 1'b0;
        fork
            begin
                send(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, {4'b0000, 32'h0000_0003});
                send(32'h0000_0064, 32'h0000_0001, 1'b1, 1'b0, {4'b1000, 32'h0000_0063});
                send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, {4'b1010, 32'hFFFF_FFFE});
            end
            begin
                repeat (4) @(negedge clk);
                for (int k = 0; k < 3; k++)
                    chk($sformatf("stall_in_ready_s%0d", k + 1), 64'(in_ready_s[k]), 64'd0);
                out_ready = 1'b1;
            end
        join
        idle(8);
        for (int k = 0; k < 3; k++)
            chk($sformatf("stall_drained_s%0d", k + 1), 64'(q_size(k)), 64'd0);
        lat_en = 1'b1;

        // Reset pulsed with two beats in flight.
        send(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, {4'b0000, 32'h0000_0007});
        send(32'h0000_0008, 32'h0000_0008, 1'b1, 1'b0, {4'b1001, 32'h0000_0000});
        rst_n = 1'b0;
        flush_exp();
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("midrst_out_valid_s%0d", k + 1), 64'(out_valid_s[k]), 64'd0);
            chk($sformatf("midrst_sum_s%0d", k + 1), 64'(sum_s[k]), 64'd0);
            chk($sformatf("midrst_flags_s%0d", k + 1), 64'(flags_s[k]), 64'd0);
            chk($sformatf("midrst_in_ready_s%0d", k + 1), 64'(in_ready_s[k]), 64'd1);
        end
        idle(2);
        rst_n = 1'b1;
        idle(6);
        for (int k = 0; k < 3; k++)
            chk($sformatf("post_midrst_out_valid_s%0d", k + 1), 64'(out_valid_s[k]), 64'd0);

        for (int k = 0; k < 3; k++)
            chk($sformatf("final_queue_s%0d", k + 1), 64'(q_size(k)), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
